// File: rtl/cr_kme_thresh_fifo.sv
// rtl/cr_kme_thresh_fifo.sv - show-ahead circular FIFO with threshold stall,
// overflow/underflow pulses, sticky error bits and an occupancy high-water mark.
module cr_kme_thresh_fifo #(
  parameter int DATA_SIZE   = 611,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_AT    = 0,
  parameter int OVERRIDE_EN = 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  input  logic                 fifo_in_stall_override,
  input  logic                 fifo_out_ack,
  input  logic                 clear,
  input  logic                 status_clr,
  output logic                 fifo_in_stall,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  output logic [CW-1:0]        used_slots,
  output logic [CW-1:0]        high_water,
  output logic [1:0]           sticky_err
);

  localparam int SW = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic [CW-1:0]        hw_base;
  logic [SW-1:0]        free_slots;
  logic                 push;
  logic                 pop;
  logic                 ovf_nxt;
  logic                 unf_nxt;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign pop  = fifo_out_ack && (count != '0);
  assign push = fifo_in_valid && ((count != FULL_CNT) || pop);

  assign ovf_nxt = !clear && fifo_in_valid && !push;
  assign unf_nxt = !clear && fifo_out_ack && (count == '0);

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= fifo_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      fifo_overflow  <= ovf_nxt;
      fifo_underflow <= unf_nxt;
    end
  end

  // status_clr restarts the watermark from the current occupancy; a new error wins over the clear.
  assign hw_base = status_clr ? count : high_water;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water <= '0;
      sticky_err <= 2'b00;
    end else begin
      high_water <= (count_nxt > hw_base) ? count_nxt : hw_base;
      sticky_err <= (status_clr ? 2'b00 : sticky_err) | {ovf_nxt, unf_nxt};
    end
  end

  assign free_slots     = SW'(FIFO_DEPTH) - {1'b0, count};
  assign fifo_in_stall  = (free_slots <= SW'(STALL_AT)) ||
                          ((OVERRIDE_EN != 0) && fifo_in_stall_override);
  assign fifo_out_valid = (count != '0);
  assign fifo_out       = fifo_out_valid ? mem[rd_ptr] : '0;
  assign used_slots     = count;

endmodule

// File: tb/tb_cr_kme_thresh_fifo.sv
// tb/tb_cr_kme_thresh_fifo.sv - scoreboard bench for cr_kme_thresh_fifo
// (DEPTH=4, STALL_AT=1, OVERRIDE_EN=1).
module tb_cr_kme_thresh_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_in = '0;
  logic          fifo_in_valid = 1'b0;
  logic          fifo_in_stall_override = 1'b0;
  logic          fifo_out_ack = 1'b0;
  logic          clear = 1'b0;
  logic          status_clr = 1'b0;
  logic          fifo_in_stall;
  logic [DW-1:0] fifo_out;
  logic          fifo_out_valid;
  logic          fifo_overflow;
  logic          fifo_underflow;
  logic [2:0]    used_slots;
  logic [2:0]    high_water;
  logic [1:0]    sticky_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  int            used_m = 0;
  int            hw_m = 0;
  logic [1:0]    sticky_m = 2'b00;
  logic          ovf_m = 1'b0;
  logic          unf_m = 1'b0;

  cr_kme_thresh_fifo #(
    .DATA_SIZE(DW), .FIFO_DEPTH(DEPTH), .STALL_AT(1), .OVERRIDE_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall_override(fifo_in_stall_override), .fifo_out_ack(fifo_out_ack),
    .clear(clear), .status_clr(status_clr), .fifo_in_stall(fifo_in_stall),
    .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid), .fifo_overflow(fifo_overflow),
    .fifo_underflow(fifo_underflow), .used_slots(used_slots), .high_water(high_water),
    .sticky_err(sticky_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of stimulus, updates the reference model, then idles inputs 1ns after the edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic a,
                       input logic clr, input logic sclr);
    logic pop;
    logic push;
    int   used_old;
    int   base;
    fifo_in       = d;
    fifo_in_valid = v;
    fifo_out_ack  = a;
    clear         = clr;
    status_clr    = sclr;
    used_old = used_m;
    pop  = a && (used_m > 0);
    push = v && ((used_m < DEPTH) || pop);
    if (clr) begin
      used_m = 0;
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      ovf_m = v && !push;
      unf_m = a && (used_m == 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      used_m = used_m + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    if (sclr) sticky_m = 2'b00;
    sticky_m = sticky_m | {ovf_m, unf_m};
    base = sclr ? used_old : hw_m;
    hw_m = (used_m > base) ? used_m : base;
    @(posedge clk);
    #1;
    fifo_in_valid = 1'b0;
    fifo_out_ack  = 1'b0;
    clear         = 1'b0;
    status_clr    = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    used_m = 0;
    hw_m = 0;
    sticky_m = 2'b00;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_in_stall_override = 1'b0;
    #3;
    n_checks++;
    if ({fifo_out_valid, fifo_out, used_slots, high_water, sticky_err, fifo_overflow, fifo_underflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b out=%h used=%0d hw=%0d sticky=%b ovf=%0b unf=%0b, required all 0",
               fifo_out_valid, fifo_out, used_slots, high_water, sticky_err, fifo_overflow, fifo_underflow);
    end
    n_checks++;
    if (fifo_in_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_no_override: got %0b required 0", fifo_in_stall);
    end
    fifo_in_stall_override = 1'b1;
    #1;
    n_checks++;
    if (fifo_in_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_override: got %0b required 1", fifo_in_stall);
    end
    fifo_in_stall_override = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (used_slots !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_used[%0d]: got %0d required %0d", i, used_slots, i + 1);
      end
      n_checks++;
      if (fifo_in_stall !== (i + 1 >= 3)) begin
        n_fail++;
        $display("FAIL fill_stall[%0d]: got %0b required %0b", i, fifo_in_stall, (i + 1 >= 3));
      end
    end
    n_checks++;
    if (fifo_out !== 32'hA || fifo_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_head: got %h valid %0b required 0000000a valid 1", fifo_out, fifo_out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] order [4] = '{32'hB, 32'hC, 32'hD, 32'hE};
    drive(1'b1, 32'hE, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (used_slots !== 3'd4 || fifo_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop: used=%0d ovf=%0b required used=4 ovf=0", used_slots, fifo_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fifo_out !== order[i] || fifo_out !== q[0]) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %h required %h", i, fifo_out, order[i]);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (fifo_out_valid !== 1'b0 || fifo_out !== '0) begin
      n_fail++;
      $display("FAIL drained_empty: valid=%0b out=%h required 0/0", fifo_out_valid, fifo_out);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_overflow !== 1'b1 || sticky_err !== 2'b10 || used_slots !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_pulse: ovf=%0b sticky=%b used=%0d required 1/10/4",
               fifo_overflow, sticky_err, used_slots);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_overflow !== 1'b0 || sticky_err !== 2'b10) begin
      n_fail++;
      $display("FAIL overflow_one_cycle: ovf=%0b sticky=%b required 0/10", fifo_overflow, sticky_err);
    end
    n_checks++;
    if (fifo_out !== 32'h100) begin
      n_fail++;
      $display("FAIL overflow_storage: head %h required 00000100", fifo_out);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (sticky_err !== 2'b00) begin
      n_fail++;
      $display("FAIL status_clr_sticky: got %b required 00", sticky_err);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hF, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (fifo_underflow !== 1'b1 || used_slots !== 3'd1 || fifo_out !== 32'hF || sticky_err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_bypassless: unf=%0b used=%0d out=%h sticky=%b required 1/1/0000000f/x1",
               fifo_underflow, used_slots, fifo_out, sticky_err);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_underflow !== 1'b0 || sticky_err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_one_cycle: unf=%0b sticky=%b required 0/x1", fifo_underflow, sticky_err);
    end
  endtask

  task automatic test_clear();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (high_water !== 3'd0 || sticky_err !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_prep: hw=%0d sticky=%b required 0/00", high_water, sticky_err);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2FF, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (used_slots !== 3'd0 || fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0 || fifo_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flush: used=%0d ovf=%0b unf=%0b valid=%0b required 0/0/0/0",
               used_slots, fifo_overflow, fifo_underflow, fifo_out_valid);
    end
    n_checks++;
    if (high_water !== 3'd3) begin
      n_fail++;
      $display("FAIL clear_high_water: got %0d required 3", high_water);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (fifo_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_suppress_unf: got %0b required 0", fifo_underflow);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (high_water !== 3'd0) begin
      n_fail++;
      $display("FAIL status_clr_high_water: got %0d required 0", high_water);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h301, 1'b0, 1'b0, 1'b0);
    #2;
    fifo_in_stall_override = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fifo_out_valid !== 1'b0 || fifo_out !== '0 || used_slots !== '0 || fifo_in_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b out=%h used=%0d stall=%0b required 0/0/0/1",
               fifo_out_valid, fifo_out, used_slots, fifo_in_stall);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo_in_stall_override = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (fifo_in_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_stall: got %0b required 0", fifo_in_stall);
    end
    drive(1'b1, 32'h3A5, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_out !== 32'h3A5 || used_slots !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_first_push: out=%h used=%0d required 000003a5/1", fifo_out, used_slots);
    end
  endtask

  task automatic test_back_to_back();
    logic          v;
    logic          a;
    logic          sc;
    logic [DW-1:0] d;
    for (int i = 0; i < 300; i++) begin
      n_checks++;
      if ((used_m != 0 && fifo_out !== q[0]) || (used_m == 0 && fifo_out !== '0)) begin
        n_fail++;
        $display("FAIL b2b_head[%0d]: got %h required %h", i, fifo_out, (used_m != 0) ? q[0] : '0);
      end
      v  = ($urandom_range(0, 99) < 60);
      a  = ($urandom_range(0, 99) < 50);
      sc = ($urandom_range(0, 99) < 5);
      d  = $urandom;
      drive(v, d, a, 1'b0, sc);
      n_checks++;
      if (used_slots !== 3'(used_m) || fifo_overflow !== ovf_m || fifo_underflow !== unf_m ||
          high_water !== 3'(hw_m) || sticky_err !== sticky_m ||
          fifo_in_stall !== ((DEPTH - used_m) <= 1)) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: used=%0d ovf=%0b unf=%0b hw=%0d sticky=%b stall=%0b required %0d/%0b/%0b/%0d/%b/%0b",
                 i, used_slots, fifo_overflow, fifo_underflow, high_water, sticky_err, fifo_in_stall,
                 used_m, ovf_m, unf_m, hw_m, sticky_m, ((DEPTH - used_m) <= 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_underflow();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
